// File: rtl/traffic_generator_gmii_scheduler_pkg.sv
// Package: traffic_generator_gmii_scheduler_pkg
// Shared definitions for the GMII traffic generator scheduler and the CPU
// register block: FSM state encodings, default counter width and the
// "0 = unlimited" setting encoding.
package traffic_generator_gmii_scheduler_pkg;

    localparam int C_CNT_WIDTH_DEF = 32;

    // A zero in frames_per_burst / total_frames disables that limit.
    localparam int C_UNLIMITED = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } sched_state_t;

endpackage

// File: rtl/traffic_generator_gmii_scheduler_if.sv
// Interface: traffic_generator_gmii_scheduler_if
// Frame handshake between the scheduler (master) and the GMII frame engine
// (slave).
//   frame_req  : scheduler -> engine, held high until frame_ack
//   frame_ack  : engine -> scheduler, 1-cycle accept pulse
//   frame_done : engine -> scheduler, 1-cycle pulse after the last byte
interface traffic_generator_gmii_scheduler_if;
    import traffic_generator_gmii_scheduler_pkg::*;

    logic frame_req;
    logic frame_ack;
    logic frame_done;

    modport master (output frame_req, input frame_ack, input frame_done);
    modport slave  (input frame_req, output frame_ack, output frame_done);

endinterface

// File: rtl/traffic_generator_gmii_scheduler_gap_timer.sv
// Module: tg_gap_timer
// Loadable down-counter used to time interframe/interburst gaps.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val (wins over i_en)
//   i_en         : decrement by one, stopping at zero
//   o_zero       : count is zero
module tg_gap_timer
    import traffic_generator_gmii_scheduler_pkg::*;
#(
    parameter int CW = C_CNT_WIDTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_generator_gmii_scheduler.sv
// Module: traffic_generator_gmii_scheduler
// Sequences the GMII frame engine into frames, bursts and runs. Settings are
// latched on the rising edge of run; one request per frame, wait for the
// engine's done pulse, then time the gap before the next request.
//   i_clk, i_rst           : core clock, synchronous active-high reset
//   i_run                  : run level; rising edge starts a run
//   i_interframe_gap       : idle cycles between frames in a burst
//   i_interburst_gap       : idle cycles after the last frame of a burst
//   i_frames_per_burst     : frames per burst, 0 = no bursting
//   i_total_frames         : frames per run, 0 = continuous
//   fe                     : frame handshake to the engine (master side)
//   o_active               : run in progress (REQ/WAIT_DONE/GAP)
//   o_run_done             : total_frames reached, held until run drops
//   o_frames_sent          : completed frames this run
//   o_bursts_sent          : completed bursts this run
module traffic_generator_gmii_scheduler
    import traffic_generator_gmii_scheduler_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic [C_CNT_WIDTH-1:0] i_interframe_gap,
    input  logic [C_CNT_WIDTH-1:0] i_interburst_gap,
    input  logic [C_CNT_WIDTH-1:0] i_frames_per_burst,
    input  logic [C_CNT_WIDTH-1:0] i_total_frames,
    traffic_generator_gmii_scheduler_if.master fe,
    output logic                   o_active,
    output logic                   o_run_done,
    output logic [C_CNT_WIDTH-1:0] o_frames_sent,
    output logic [C_CNT_WIDTH-1:0] o_bursts_sent
);

    localparam int CW = C_CNT_WIDTH;
    localparam logic [CW-1:0] C_UNL = CW'(C_UNLIMITED);

    sched_state_t  r_state, w_state_nxt;
    logic          r_run_q, r_run_d;
    logic [CW-1:0] r_ifg, r_ibg, r_fpb, r_total;
    logic [CW-1:0] r_frames, r_bursts, r_bpos;
    logic [CW-1:0] w_frames_nxt, w_bursts_nxt, w_bpos_nxt, w_gap;
    logic [CW-1:0] w_tmr_val;
    logic          w_start, w_latch, w_decide, w_tmr_load, w_tmr_en, w_tmr_zero;

    assign w_start = r_run_q & ~r_run_d;

    tg_gap_timer #(.CW(CW)) u_gap_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames;
        w_bursts_nxt = r_bursts;
        w_bpos_nxt   = r_bpos;
        w_gap        = r_ifg;
        w_latch      = 1'b0;
        w_decide     = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_latch      = 1'b1;
                    w_frames_nxt = '0;
                    w_bursts_nxt = '0;
                    w_bpos_nxt   = '0;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                // An accepted frame is in flight even if run dropped the
                // same cycle; ack+done together means the frame already ended.
                if (fe.frame_ack) begin
                    if (fe.frame_done) w_decide = 1'b1;
                    else               w_state_nxt = ST_WAIT_DONE;
                end else if (!r_run_q) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (fe.frame_done) w_decide = 1'b1;
            end
            ST_GAP: begin
                if (!r_run_q) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_zero) w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                if (!r_run_q) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Frame completed: count it, then pick DONE, IDLE or the next gap.
        if (w_decide) begin
            w_frames_nxt = r_frames + CW'(1);
            w_bpos_nxt   = r_bpos + CW'(1);
            if ((r_total != C_UNL) && (w_frames_nxt == r_total)) begin
                // The final frame closes the (possibly partial) current burst.
                if (r_fpb != C_UNL) w_bursts_nxt = r_bursts + CW'(1);
                w_state_nxt = ST_DONE;
            end else begin
                if ((r_fpb != C_UNL) && (w_bpos_nxt == r_fpb)) begin
                    w_bursts_nxt = r_bursts + CW'(1);
                    w_bpos_nxt   = '0;
                    w_gap        = r_ibg;
                end
                if (!r_run_q) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gap == '0) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    // Timer holds gap-1 in the first GAP cycle so the next
                    // request lands exactly gap cycles after the done cycle + 1.
                    w_state_nxt = ST_GAP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = w_gap - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            // Treat run as already high out of reset so a level held across
            // reset release is not mistaken for a rising edge.
            r_run_q  <= 1'b1;
            r_run_d  <= 1'b1;
            r_ifg    <= '0;
            r_ibg    <= '0;
            r_fpb    <= '0;
            r_total  <= '0;
            r_frames <= '0;
            r_bursts <= '0;
            r_bpos   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_run_q  <= i_run;
            r_run_d  <= r_run_q;
            r_frames <= w_frames_nxt;
            r_bursts <= w_bursts_nxt;
            r_bpos   <= w_bpos_nxt;
            if (w_latch) begin
                r_ifg   <= i_interframe_gap;
                r_ibg   <= i_interburst_gap;
                r_fpb   <= i_frames_per_burst;
                r_total <= i_total_frames;
            end
        end
    end

    assign fe.frame_req  = (r_state == ST_REQ);
    assign o_active      = (r_state == ST_REQ) || (r_state == ST_WAIT_DONE) || (r_state == ST_GAP);
    assign o_run_done    = (r_state == ST_DONE);
    assign o_frames_sent = r_frames;
    assign o_bursts_sent = r_bursts;

endmodule

// File: tb/tb_traffic_generator_gmii_scheduler.sv
module tb_traffic_generator_gmii_scheduler;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [CW-1:0] ifg, ibg, fpb, total;
    logic          active, run_done;
    logic [CW-1:0] frames_sent, bursts_sent;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    traffic_generator_gmii_scheduler_if u_fe ();

    traffic_generator_gmii_scheduler #(.C_CNT_WIDTH(CW)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_run              (run),
        .i_interframe_gap   (ifg),
        .i_interburst_gap   (ibg),
        .i_frames_per_burst (fpb),
        .i_total_frames     (total),
        .fe                 (u_fe),
        .o_active           (active),
        .o_run_done         (run_done),
        .o_frames_sent      (frames_sent),
        .o_bursts_sent      (bursts_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Wait (bounded) for frame_req; returns the cycle it was seen.
    task automatic wait_req(input string tag, output int t_req);
        int n = 0;
        while (u_fe.frame_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(u_fe.frame_req), 64'd1);
        t_req = cyc;
    endtask

    // Engine model: ack after ack_dly cycles, done done_dly cycles after ack.
    task automatic serve(input int ack_dly, input int done_dly, output int t_done);
        ticks(ack_dly);
        u_fe.frame_ack = 1'b1;
        tick();
        u_fe.frame_ack = 1'b0;
        chk("req_drop_after_ack", 64'(u_fe.frame_req), 64'd0);
        ticks(done_dly - 1);
        u_fe.frame_done = 1'b1;
        t_done = cyc;
        tick();
        u_fe.frame_done = 1'b0;
    endtask

    initial begin
        int td, tr;
        int exp_gap [7];
        exp_gap = '{3, 3, 3, 21, 3, 3, 3};

        rst = 1'b1; run = 1'b0;
        ifg = '0; ibg = '0; fpb = '0; total = '0;
        u_fe.frame_ack = 1'b0; u_fe.frame_done = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();
        chk("rst_req", 64'(u_fe.frame_req), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_run_done", 64'(run_done), 64'd0);
        chk("rst_frames", 64'(frames_sent), 64'd0);
        chk("rst_bursts", 64'(bursts_sent), 64'd0);

        // 1: IFG=12, no bursting, 3 frames
        ifg = 12; ibg = 0; fpb = 0; total = 3;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req("t1_req", tr);
            if (i > 0) chk("t1_gap", 64'(tr - td), 64'd13);
            serve(1, 64, td);
        end
        chk("t1_frames", 64'(frames_sent), 64'd3);
        chk("t1_run_done", 64'(run_done), 64'd1);
        chk("t1_active", 64'(active), 64'd0);
        chk("t1_bursts", 64'(bursts_sent), 64'd0);
        ticks(20);
        chk("t1_no_restart", 64'(u_fe.frame_req), 64'd0);
        chk("t1_done_held", 64'(run_done), 64'd1);
        run = 1'b0;
        ticks(2);
        chk("t1_done_clr", 64'(run_done), 64'd0);

        // 2: bursts of 4, 8 frames total
        ifg = 2; ibg = 20; fpb = 4; total = 8;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_req("t2_req", tr);
            if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(tr - td), 64'(exp_gap[i-1]));
            if (i == 4) chk("t2_bursts_mid", 64'(bursts_sent), 64'd1);
            serve(1, 5, td);
        end
        chk("t2_bursts", 64'(bursts_sent), 64'd2);
        chk("t2_frames", 64'(frames_sent), 64'd8);
        chk("t2_run_done", 64'(run_done), 64'd1);
        run = 1'b0;
        ticks(2);

        // 3: continuous, IFG=0 back-to-back; drop run during WAIT_DONE
        ifg = 0; ibg = 0; fpb = 0; total = 0;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req("t3_req", tr);
            if (i > 0) chk("t3_gap", 64'(tr - td), 64'd1);
            serve(1, 3, td);
        end
        wait_req("t3_req4", tr);
        chk("t3_gap4", 64'(tr - td), 64'd1);
        u_fe.frame_ack = 1'b1;
        tick();
        u_fe.frame_ack = 1'b0;
        run = 1'b0;
        ticks(3);
        chk("t3_inflight_active", 64'(active), 64'd1);
        u_fe.frame_done = 1'b1;
        tick();
        u_fe.frame_done = 1'b0;
        chk("t3_frames", 64'(frames_sent), 64'd4);
        chk("t3_idle", 64'(active), 64'd0);
        ticks(5);
        chk("t3_no_req", 64'(u_fe.frame_req), 64'd0);

        // 4: drop run in GAP, then drop run in REQ before ack
        ifg = 100;
        run = 1'b1;
        wait_req("t4_req", tr);
        serve(1, 3, td);
        ticks(5);
        chk("t4_in_gap", 64'(active), 64'd1);
        run = 1'b0;
        ticks(2);
        chk("t4_gap_idle", 64'(active), 64'd0);
        chk("t4_frames", 64'(frames_sent), 64'd1);
        run = 1'b1;
        wait_req("t4_req2", tr);
        run = 1'b0;
        tick();
        chk("t4_req_still", 64'(u_fe.frame_req), 64'd1);
        tick();
        chk("t4_req_drop", 64'(u_fe.frame_req), 64'd0);
        chk("t4_req_idle", 64'(active), 64'd0);
        chk("t4_frames2", 64'(frames_sent), 64'd0);

        // 5: reset mid-WAIT_DONE, run held high through reset release
        ifg = 5; total = 0; fpb = 0;
        run = 1'b1;
        wait_req("t5_req", tr);
        serve(1, 2, td);
        wait_req("t5_req2", tr);
        u_fe.frame_ack = 1'b1;
        tick();
        u_fe.frame_ack = 1'b0;
        ticks(3);
        chk("t5_wait", 64'(active), 64'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_req", 64'(u_fe.frame_req), 64'd0);
        chk("t5_rst_active", 64'(active), 64'd0);
        chk("t5_rst_frames", 64'(frames_sent), 64'd0);
        ticks(2);
        rst = 1'b0;
        ticks(10);
        chk("t5_no_start", 64'(u_fe.frame_req), 64'd0);
        chk("t5_no_active", 64'(active), 64'd0);
        run = 1'b0;
        ticks(3);
        run = 1'b1;
        wait_req("t5_restart", tr);
        serve(1, 2, td);
        chk("t5_frames", 64'(frames_sent), 64'd1);
        run = 1'b0;
        ticks(3);

        // 6: ack+done together, spurious done in GAP, config change mid-run
        ifg = 4; total = 0; fpb = 0;
        run = 1'b1;
        wait_req("t6_req", tr);
        u_fe.frame_ack = 1'b1;
        u_fe.frame_done = 1'b1;
        td = cyc;
        tick();
        u_fe.frame_ack = 1'b0;
        u_fe.frame_done = 1'b0;
        chk("t6_same_cycle_frames", 64'(frames_sent), 64'd1);
        chk("t6_in_gap_req", 64'(u_fe.frame_req), 64'd0);
        u_fe.frame_done = 1'b1;
        tick();
        u_fe.frame_done = 1'b0;
        chk("t6_spurious_done", 64'(frames_sent), 64'd1);
        wait_req("t6_req2", tr);
        chk("t6_gap", 64'(tr - td), 64'd5);
        ifg = 0;
        serve(1, 3, td);
        wait_req("t6_req3", tr);
        chk("t6_cfg_ignored", 64'(tr - td), 64'd5);
        serve(1, 3, td);
        run = 1'b0;
        ticks(3);
        chk("t6_hold_frames", 64'(frames_sent), 64'd3);
        total = 2;
        run = 1'b1;
        wait_req("t6_new_req", tr);
        serve(1, 3, td);
        wait_req("t6_new_req2", tr);
        chk("t6_new_cfg_gap", 64'(tr - td), 64'd1);
        serve(1, 3, td);
        chk("t6_new_done", 64'(run_done), 64'd1);
        chk("t6_new_frames", 64'(frames_sent), 64'd2);
        run = 1'b0;
        ticks(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
